// File: rtl/tcm_lsu_port_if.sv
// tcm_lsu_port_if: core request/response channel plus TCM port-0 bus for tcm_lsu_port
interface tcm_lsu_port_if #(parameter int ADDR_WIDTH = 16);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [31:0]           req_addr_i;
  logic                  req_we_i;
  logic [1:0]            req_size_i;
  logic                  req_signed_i;
  logic [31:0]           req_wdata_i;
  logic                  resp_valid_o;
  logic                  resp_ready_i;
  logic [31:0]           resp_rdata_o;
  logic                  resp_err_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_data_o;
  logic [3:0]            mem_wr_o;
  logic [31:0]           mem_data_i;
  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_size_i, req_signed_i, req_wdata_i,
    input  resp_ready_i, mem_data_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, mem_addr_o, mem_data_o, mem_wr_o
  );
  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_size_i, req_signed_i, req_wdata_i,
    output resp_ready_i, mem_data_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, mem_addr_o, mem_data_o, mem_wr_o
  );
endinterface

// File: rtl/tcm_lsu_port.sv
// tcm_lsu_port: load/store adapter onto TCM port 0; define TCM_LSU_MISALIGN_CHK_EN to fault misaligned half/word accesses
module tcm_lsu_port #(parameter int ADDR_WIDTH = 16) (
  input logic            clk_i,
  input logic            rst_i,
  tcm_lsu_port_if.slave  bus
);
  typedef struct packed {
    logic       v;
    logic [1:0] off;
    logic [1:0] size;
    logic       sgn;
    logic       we;
    logic       err;
  } pend_t;
  pend_t       pend_q;
  logic        out_v_q, out_e_q, skid_v_q, skid_e_q;
  logic [31:0] out_d_q, skid_d_q;
  logic [1:0]  off, size;
  logic        err, acc, drain;
  logic [3:0]  strb;
  logic [31:0] sh, res;
  logic        unused_addr;
  assign size = bus.req_size_i;
  assign unused_addr = ^bus.req_addr_i[31:ADDR_WIDTH];
`ifdef TCM_LSU_MISALIGN_CHK_EN
  logic mis;
  assign mis = (size == 2'b01 & bus.req_addr_i[0]) | (size == 2'b10 & |bus.req_addr_i[1:0]);
  assign off = bus.req_addr_i[1:0];
  assign err = &size | mis;
`else
  assign off = size == 2'b10 ? 2'b00 : size == 2'b01 ? {bus.req_addr_i[1], 1'b0} : bus.req_addr_i[1:0];
  assign err = &size;
`endif
  assign strb  = size == 2'b00 ? 4'b0001 << off : size == 2'b01 ? 4'b0011 << off : 4'b1111;
  assign drain = out_v_q & bus.resp_ready_i;
  assign acc   = bus.req_valid_i & bus.req_ready_o;
  assign bus.req_ready_o  = ~skid_v_q & ~(pend_q.v & out_v_q & ~bus.resp_ready_i);
  assign bus.mem_addr_o   = {2'b00, bus.req_addr_i[ADDR_WIDTH-1:2]};
  assign bus.mem_data_o   = size == 2'b00 ? {4{bus.req_wdata_i[7:0]}} :
                            size == 2'b01 ? {2{bus.req_wdata_i[15:0]}} : bus.req_wdata_i;
  assign bus.mem_wr_o     = (acc & bus.req_we_i & ~err & rst_i) ? strb : 4'b0000;
  assign bus.resp_valid_o = out_v_q;
  assign bus.resp_rdata_o = out_d_q;
  assign bus.resp_err_o   = out_e_q;
  // Align the registered RAM word for the pending load and extend it; stores and faults return 0
  always_comb begin
    sh  = bus.mem_data_i >> {pend_q.off, 3'b000};
    res = (pend_q.we | pend_q.err) ? 32'h0 :
          pend_q.size == 2'b00 ? {{24{pend_q.sgn & sh[7]}}, sh[7:0]} :
          pend_q.size == 2'b01 ? {{16{pend_q.sgn & sh[15]}}, sh[15:0]} : sh;
  end
  // Remember what was accepted this cycle so its RAM data can be aligned next cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) pend_q <= '0;
    else pend_q <= '{v: acc, off: off, size: size, sgn: bus.req_signed_i, we: bus.req_we_i, err: err};
  end
  // Output register plus skid: results enter in order, skid always drains into the output first
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_v_q  <= 1'b0;
      out_d_q  <= '0;
      out_e_q  <= 1'b0;
      skid_v_q <= 1'b0;
      skid_d_q <= '0;
      skid_e_q <= 1'b0;
    end else if (pend_q.v) begin
      if (!out_v_q | drain) begin
        out_v_q  <= 1'b1;
        out_d_q  <= skid_v_q ? skid_d_q : res;
        out_e_q  <= skid_v_q ? skid_e_q : pend_q.err;
        skid_d_q <= res;
        skid_e_q <= pend_q.err;
      end else begin
        skid_v_q <= 1'b1;
        skid_d_q <= res;
        skid_e_q <= pend_q.err;
      end
    end else if (drain) begin
      out_v_q  <= skid_v_q;
      out_d_q  <= skid_d_q;
      out_e_q  <= skid_e_q;
      skid_v_q <= 1'b0;
    end
  end
endmodule

// File: doc/tcm_lsu_port.md
# tcm_lsu_port

Load/store adapter between the core's data-memory request channel and port 0 of the dual-port TCM RAM. Accepts byte-addressed load/store requests with size and signedness, and drives the RAM's word address, byte write strobes and lane-replicated write data. It then captures the RAM's registered read data one cycle later, and returns a lane-aligned, sign/zero-extended response. A two-entry output buffer (response register plus skid) gives full throughput under continuous `resp_ready` and lossless backpressure otherwise.

## Interface
- `ADDR_WIDTH`, 16: byte-address bits decoded by the TCM; RAM word index is `req_addr_i[ADDR_WIDTH-1:2]`.
- `clk_i`  in  1  clock, all state on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  request accepted when `req_valid_i & req_ready_o`.
- `req_addr_i`  in  32  byte address; bits above `ADDR_WIDTH-1` ignored.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_signed_i`  in  1  sign-extend load result.
- `req_wdata_i`  in  32  store data, right-justified.
- `resp_valid_o`  out  1  response present.
- `resp_ready_i`  in  1  response consumed when `resp_valid_o & resp_ready_i`.
- `resp_rdata_o`  out  32  load result; 0 for stores and errors.
- `resp_err_o`  out  1  request faulted; no RAM write performed.
- `mem_addr_o`  out  ADDR_WIDTH  `{2'b00, req_addr_i[ADDR_WIDTH-1:2]}`.
- `mem_data_o`  out  32  lane-replicated write data.
- `mem_wr_o`  out  4  byte write strobes.
- `mem_data_i`  in  32  RAM registered read data (valid the cycle after address).

## Operation
- Accept: `mem_addr_o` follows `req_addr_i` combinationally every cycle. `mem_wr_o` is nonzero only on an accepted, non-faulting store.
- Strobes: byte `4'b0001 << addr[1:0]`; half `4'b0011 << {addr[1],1'b0}`; word `4'b1111`.
- Write data: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word `wdata`.
- Fault conditions: size 11 always faults; misaligned accesses fault per Configuration. A faulting request is still accepted and produces a response with `resp_err_o=1` and `resp_rdata_o=0`.
- Pending stage `pend_q` holds offset, size, signed, we and err for the request accepted last cycle.
- Align stage: `mem_data_i >> (8*offset)`, truncate to size, extend per `req_signed`. Stores return 0.
- Routing: the aligned result goes to the output register if it is empty or draining this cycle; otherwise it goes to the skid. When the output drains and the skid is full, the skid moves to the output and the new result goes to the skid.
- `req_ready_o = ~skid_v_q & ~(pend_q & resp_valid_o & ~resp_ready_i)`.
- Responses are returned strictly in request order. No entry is dropped or duplicated.

## Timing
- Reset values: `pend_q`, `skid_v_q` and `resp_valid_o` are 0. `resp_rdata_o` and `resp_err_o` are 0. `req_ready_o` is 1 and `mem_wr_o` is 0 during and after reset.
- Latency: accept at cycle N, `resp_valid_o` at N+2. Throughput is 1 per cycle with `resp_ready_i` held high.
- Stall: with `resp_ready_i` low, the block accepts at most 2 further requests before `req_ready_o` drops. `req_ready_o` rises again the cycle after the skid empties.
- Writes commit at the RAM on the accept edge (N+1). A load to the same word accepted at N+1 sees the new data.
- Reset mid-operation discards all pending, skid and output entries immediately. A store already strobed has committed; an in-flight store receives no response.

## Configuration
- `TCM_LSU_MISALIGN_CHK_EN` defined: a half at odd offset, or a word at nonzero offset, faults (err=1, no write).
- Undefined: low address bits are forced to alignment (half uses `addr[1]`, word ignores `addr[1:0]`). No misalign fault is raised; size 11 still faults.

## Test plan
- Store word 0xDEADBEEF at 0x10000, then load word → strobes 4'b1111, `resp_rdata_o`=0xDEADBEEF at accept+2, err=0.
- Load byte signed at 0x10003 → 0xFFFFFFDE. Load half unsigned at 0x10002 → 0x0000DEAD.
- Store byte 0x5A at 0x10001, then load word → `mem_wr_o`=4'b0010, `mem_data_o`=0x5A5A5A5A, readback 0xDEAD5AEF.
- Four back-to-back loads with `resp_ready_i` low for 4 cycles → `req_ready_o` drops after 2 accepts; all 4 responses return in order, none lost.
- Word load at 0x10001 → with macro: err=1, rdata=0. Without macro: rdata = word at 0x10000.
- Assert `rst_i` low with skid full → `resp_valid_o`=0 and `req_ready_o`=1 immediately; no stale response after release.
